// File: rtl/user_edge_job_ctrl.sv
// Edge-mask job sequencer: OBI config port, one read-modify-write per word over the OBI manager port.
// Config response 1 cycle after grant; manager holds req/addr/wdata until gnt, one txn outstanding, >=4 cycles/word.
module user_edge_job_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sbr_obi_req_i,
    input  logic [ADDR_WIDTH-1:0] sbr_obi_addr_i,
    input  logic [DATA_WIDTH-1:0] sbr_obi_wdata_i,
    input  logic                  sbr_obi_we_i,
    input  logic [ID_WIDTH-1:0]   sbr_obi_id_i,
    output logic                  sbr_obi_gnt_o,
    output logic                  sbr_obi_rvalid_o,
    output logic [DATA_WIDTH-1:0] sbr_obi_rdata_o,
    output logic [ID_WIDTH-1:0]   sbr_obi_rid_o,
    output logic                  sbr_obi_err_o,
    output logic                  mgr_obi_req_o,
    output logic [ADDR_WIDTH-1:0] mgr_obi_addr_o,
    output logic [DATA_WIDTH-1:0] mgr_obi_wdata_o,
    output logic                  mgr_obi_we_o,
    output logic [ID_WIDTH-1:0]   mgr_obi_id_o,
    input  logic                  mgr_obi_gnt_i,
    input  logic                  mgr_obi_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mgr_obi_rdata_i,
    input  logic                  mgr_obi_err_i,
    output logic                  irq_o
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        ABORT
    } state_e;

    state_e state_q, state_d;

    logic                  irq_en_q;
    logic [ADDR_WIDTH-1:0] src_q, dst_q;
    logic [LEN_WIDTH-1:0]  len_q, progress_q, progress_inc;
    logic                  done_q, err_q, carry_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  rsp_vld_q, rsp_err_q;
    logic [ID_WIDTH-1:0]   rsp_id_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, reg_rdata;

    logic                  busy, sbr_wr, cfg_wr_blocked, start, status_w1c, last_word;
    logic [2:0]            reg_sel;
    logic [ADDR_WIDTH-1:0] word_off;

    assign busy           = (state_q != IDLE);
    assign reg_sel        = sbr_obi_addr_i[4:2];
    assign sbr_wr         = sbr_obi_req_i & sbr_obi_we_i;
    assign cfg_wr_blocked = sbr_wr & busy & (reg_sel < 3'd4);
    assign start          = sbr_wr & ~busy & (reg_sel == 3'd0) & sbr_obi_wdata_i[0];
    assign status_w1c     = sbr_wr & (reg_sel == 3'd4);
    assign progress_inc   = progress_q + LEN_WIDTH'(1);
    assign last_word      = (progress_inc == len_q);
    // PROGRESS doubles as the word index for both pointers
    assign word_off       = ADDR_WIDTH'({progress_q, 2'b00});

    always_comb begin
        reg_rdata = '0;
        case (reg_sel)
            3'd0:    reg_rdata[1] = irq_en_q;
            3'd1:    reg_rdata[ADDR_WIDTH-1:0] = src_q;
            3'd2:    reg_rdata[ADDR_WIDTH-1:0] = dst_q;
            3'd3:    reg_rdata[LEN_WIDTH-1:0] = len_q;
            3'd4:    reg_rdata[2:0] = {err_q, done_q, busy};
            3'd5:    reg_rdata[LEN_WIDTH-1:0] = progress_q;
            default: reg_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && len_q != '0) state_d = RD_REQ;
            RD_REQ:  if (mgr_obi_gnt_i) state_d = RD_WAIT;
            RD_WAIT: if (mgr_obi_rvalid_i) state_d = mgr_obi_err_i ? ABORT : WR_REQ;
            WR_REQ:  if (mgr_obi_gnt_i) state_d = WR_WAIT;
            WR_WAIT: begin
                if (mgr_obi_rvalid_i) begin
                    if (mgr_obi_err_i)  state_d = ABORT;
                    else if (last_word) state_d = IDLE;
                    else                state_d = RD_REQ;
                end
            end
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_en_q    <= 1'b0;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            progress_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            carry_q     <= 1'b0;
            wdata_q     <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_vld_q   <= sbr_obi_req_i;
            rsp_id_q    <= sbr_obi_req_i ? sbr_obi_id_i : '0;
            rsp_err_q   <= cfg_wr_blocked;
            rsp_rdata_q <= (sbr_obi_req_i && !sbr_obi_we_i) ? reg_rdata : '0;

            if (sbr_wr && !busy) begin
                case (reg_sel)
                    3'd0:    irq_en_q <= sbr_obi_wdata_i[1];
                    3'd1:    src_q    <= {sbr_obi_wdata_i[ADDR_WIDTH-1:2], 2'b00};
                    3'd2:    dst_q    <= {sbr_obi_wdata_i[ADDR_WIDTH-1:2], 2'b00};
                    3'd3:    len_q    <= sbr_obi_wdata_i[LEN_WIDTH-1:0];
                    default: ;
                endcase
            end

            if (status_w1c) begin
                if (sbr_obi_wdata_i[1]) done_q <= 1'b0;
                if (sbr_obi_wdata_i[2]) err_q  <= 1'b0;
            end

            if (start) begin
                if (len_q == '0) begin
                    done_q <= 1'b1;
                end else begin
                    done_q     <= 1'b0;
                    err_q      <= 1'b0;
                    progress_q <= '0;
                    carry_q    <= 1'b0;
                end
            end

            // FSM-driven status updates come last so they win over a same-cycle W1C
            case (state_q)
                RD_WAIT: begin
                    if (mgr_obi_rvalid_i && !mgr_obi_err_i) begin
                        wdata_q <= mgr_obi_rdata_i ^ {carry_q, mgr_obi_rdata_i[DATA_WIDTH-1:1]};
                        carry_q <= mgr_obi_rdata_i[0];
                    end
                end
                WR_WAIT: begin
                    if (mgr_obi_rvalid_i && !mgr_obi_err_i) begin
                        progress_q <= progress_inc;
                        if (last_word) done_q <= 1'b1;
                    end
                end
                ABORT: begin
                    err_q  <= 1'b1;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sbr_obi_gnt_o    = sbr_obi_req_i;
    assign sbr_obi_rvalid_o = rsp_vld_q;
    assign sbr_obi_rdata_o  = rsp_rdata_q;
    assign sbr_obi_rid_o    = rsp_id_q;
    assign sbr_obi_err_o    = rsp_err_q;

    assign mgr_obi_req_o   = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign mgr_obi_we_o    = (state_q == WR_REQ);
    assign mgr_obi_addr_o  = (state_q == RD_REQ) ? src_q + word_off :
                             (state_q == WR_REQ) ? dst_q + word_off : '0;
    assign mgr_obi_wdata_o = (state_q == WR_REQ) ? wdata_q : '0;
    assign mgr_obi_id_o    = '0;

    assign irq_o = done_q & irq_en_q;

    logic unused_sbr_bits;
    assign unused_sbr_bits = ^{sbr_obi_addr_i[ADDR_WIDTH-1:5], sbr_obi_addr_i[1:0],
                               sbr_obi_wdata_i[DATA_WIDTH-1:ADDR_WIDTH]};

endmodule

// File: tb/tb_user_edge_job_ctrl.sv
// Bench for user_edge_job_ctrl: register vector table plus directed job sequences against an SRAM responder.
`timescale 1ns/1ps
module tb_user_edge_job_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sbr_req = 1'b0, sbr_we = 1'b0;
    logic [15:0] sbr_addr = '0;
    logic [31:0] sbr_wdata = '0;
    logic [3:0]  sbr_id = '0;
    logic        sbr_gnt, sbr_rvalid, sbr_err;
    logic [31:0] sbr_rdata;
    logic [3:0]  sbr_rid;
    logic        mgr_req, mgr_we, irq;
    logic [15:0] mgr_addr;
    logic [31:0] mgr_wdata;
    logic [3:0]  mgr_id;
    logic        mgr_gnt, mgr_rvalid, mgr_err;
    logic [31:0] mgr_rdata;

    always #5 clk = ~clk;

    user_edge_job_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .sbr_obi_req_i(sbr_req), .sbr_obi_addr_i(sbr_addr), .sbr_obi_wdata_i(sbr_wdata),
        .sbr_obi_we_i(sbr_we), .sbr_obi_id_i(sbr_id), .sbr_obi_gnt_o(sbr_gnt),
        .sbr_obi_rvalid_o(sbr_rvalid), .sbr_obi_rdata_o(sbr_rdata), .sbr_obi_rid_o(sbr_rid),
        .sbr_obi_err_o(sbr_err),
        .mgr_obi_req_o(mgr_req), .mgr_obi_addr_o(mgr_addr), .mgr_obi_wdata_o(mgr_wdata),
        .mgr_obi_we_o(mgr_we), .mgr_obi_id_o(mgr_id), .mgr_obi_gnt_i(mgr_gnt),
        .mgr_obi_rvalid_i(mgr_rvalid), .mgr_obi_rdata_i(mgr_rdata), .mgr_obi_err_i(mgr_err),
        .irq_o(irq)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    // SRAM model and responder knobs
    logic [31:0] mem [0:16383];
    int stall_max   = 0;
    bit block_wr    = 1'b0;
    int err_on_read = 0;
    int rd_count    = 0;
    int txn_count   = 0;
    int req_cycles  = 0;
    int stab_err    = 0;

    // Decides gnt at negedge for the coming posedge; responds at the following negedge
    initial begin : responder
        bit          pend, pend_we, pend_err, waiting, w_we;
        logic [15:0] pend_addr, w_addr;
        logic [31:0] pend_wdata, w_wdata;
        int          stall_left;
        mgr_gnt = 0; mgr_rvalid = 0; mgr_rdata = '0; mgr_err = 0;
        pend = 0; pend_we = 0; pend_err = 0; waiting = 0; w_we = 0;
        pend_addr = '0; w_addr = '0; pend_wdata = '0; w_wdata = '0; stall_left = 0;
        forever begin
            @(negedge clk);
            mgr_rvalid = 0; mgr_rdata = '0; mgr_err = 0;
            if (pend && !rst) begin
                mgr_rvalid = 1;
                mgr_err    = pend_err;
                if (pend_we) mem[pend_addr[15:2]] = pend_wdata;
                else         mgr_rdata = mem[pend_addr[15:2]];
            end
            pend    = 0;
            mgr_gnt = 0;
            if (rst) begin
                waiting = 0; stall_left = 0;
            end else if (mgr_req) begin
                req_cycles++;
                if (waiting && (mgr_addr !== w_addr || mgr_we !== w_we || mgr_wdata !== w_wdata))
                    stab_err++;
                waiting = 1; w_addr = mgr_addr; w_we = mgr_we; w_wdata = mgr_wdata;
                if (block_wr && mgr_we) begin
                end else if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    mgr_gnt = 1; pend = 1; pend_err = 0;
                    pend_we = mgr_we; pend_addr = mgr_addr; pend_wdata = mgr_wdata;
                    txn_count++;
                    if (!mgr_we) begin
                        rd_count++;
                        if (rd_count == err_on_read) pend_err = 1;
                    end
                    waiting    = 0;
                    stall_left = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Issued at posedge+1; response sampled at posedge+1 one cycle later
    task automatic sbr_access(input bit we, input logic [2:0] sel, input logic [31:0] wd,
                              input logic [3:0] id, output logic [31:0] rd, output logic er,
                              output logic vld, output logic [3:0] rid, output logic gnt);
        sbr_req = 1; sbr_we = we; sbr_addr = {11'h0, sel, 2'b00}; sbr_wdata = wd; sbr_id = id;
        #2 gnt = sbr_gnt;
        @(posedge clk); #1;
        sbr_req = 0; sbr_we = 0; sbr_addr = '0; sbr_wdata = '0; sbr_id = '0;
        rd = sbr_rdata; er = sbr_err; vld = sbr_rvalid; rid = sbr_rid;
    endtask

    task automatic sbr_chk(input string name, input bit we, input logic [2:0] sel,
                           input logic [31:0] wd, input logic [3:0] id,
                           input bit chk_rd, input logic [31:0] exp_rd, input bit exp_err);
        logic [31:0] rd; logic er, vld, gnt; logic [3:0] rid;
        sbr_access(we, sel, wd, id, rd, er, vld, rid, gnt);
        check({name, " rsp"}, 32'({gnt, vld, rid, er}), 32'({1'b1, 1'b1, id, exp_err}));
        if (chk_rd) check({name, " rdata"}, rd, exp_rd);
    endtask

    task automatic cfg(input logic [2:0] sel, input logic [31:0] wd);
        sbr_chk("cfg", 1'b1, sel, wd, 4'h1, 1'b1, 32'h0, 1'b0);
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] rd; logic er, vld, gnt; logic [3:0] rid;
        bit idle = 0;
        for (int i = 0; i < 2000 && !idle; i++) begin
            sbr_access(1'b0, 3'd4, 32'h0, 4'h0, rd, er, vld, rid, gnt);
            if (vld && !rd[0]) idle = 1;
        end
        check({name, " idle within bound"}, 32'(idle), 32'd1);
    endtask

    function automatic logic [31:0] edge_op(input logic [31:0] w, input logic c);
        return w ^ {c, w[31:1]};
    endfunction

    typedef struct {
        bit          we;
        logic [2:0]  sel;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t        vecs[$];
        logic [31:0] expd [0:15];
        logic        c;
        int          t0, q0;

        for (int i = 0; i < 16384; i++) mem[i] = 32'hDEAD_BEEF;

        // reset state and register access (back-to-back requests)
        vecs.push_back('{1'b0, 3'd0, 32'h0,         32'h0});
        vecs.push_back('{1'b0, 3'd1, 32'h0,         32'h0});
        vecs.push_back('{1'b0, 3'd2, 32'h0,         32'h0});
        vecs.push_back('{1'b0, 3'd3, 32'h0,         32'h0});
        vecs.push_back('{1'b0, 3'd4, 32'h0,         32'h0});
        vecs.push_back('{1'b0, 3'd5, 32'h0,         32'h0});
        vecs.push_back('{1'b0, 3'd6, 32'h0,         32'h0});
        vecs.push_back('{1'b0, 3'd7, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 3'd1, 32'h0000_1237, 32'h0});
        vecs.push_back('{1'b0, 3'd1, 32'h0,         32'h0000_1234});
        vecs.push_back('{1'b1, 3'd1, 32'h0001_2345, 32'h0});
        vecs.push_back('{1'b0, 3'd1, 32'h0,         32'h0000_2344});
        vecs.push_back('{1'b1, 3'd2, 32'h0000_ABCF, 32'h0});
        vecs.push_back('{1'b0, 3'd2, 32'h0,         32'h0000_ABCC});
        vecs.push_back('{1'b1, 3'd3, 32'hFFFF_F123, 32'h0});
        vecs.push_back('{1'b0, 3'd3, 32'h0,         32'h0000_0123});
        vecs.push_back('{1'b1, 3'd0, 32'h0000_0002, 32'h0});
        vecs.push_back('{1'b0, 3'd0, 32'h0,         32'h0000_0002});
        vecs.push_back('{1'b1, 3'd0, 32'h0000_0000, 32'h0});
        vecs.push_back('{1'b0, 3'd0, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 3'd6, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1'b0, 3'd6, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 3'd4, 32'h0000_0006, 32'h0});
        vecs.push_back('{1'b0, 3'd4, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 3'd5, 32'h0000_0055, 32'h0});
        vecs.push_back('{1'b0, 3'd5, 32'h0,         32'h0});

        tick(3);
        rst = 0;
        check("reset outputs", 32'({mgr_req, mgr_we, mgr_id, sbr_rvalid, sbr_rid, sbr_err, irq}), 32'h0);

        foreach (vecs[i])
            sbr_chk($sformatf("vec%0d", i), vecs[i].we, vecs[i].sel, vecs[i].wd, 4'(i),
                    1'b1, vecs[i].exp_rd, 1'b0);

        // reset while a write is waiting for its grant
        block_wr = 1;
        cfg(3'd1, 32'h300); cfg(3'd2, 32'h380); cfg(3'd3, 32'd4); cfg(3'd0, 32'h3);
        t0 = 0;
        while (!(mgr_req && mgr_we) && t0 < 50) begin tick(1); t0++; end
        check("reach WR_REQ", 32'(mgr_req && mgr_we), 32'd1);
        rst = 1; tick(1); rst = 0;
        block_wr = 0;
        check("rst ctl outs", 32'({sbr_gnt, mgr_req, mgr_we, mgr_id, sbr_rvalid, sbr_rid, sbr_err, irq}), 32'h0);
        check("rst mgr addr", 32'(mgr_addr), 32'h0);
        check("rst mgr wdata", mgr_wdata, 32'h0);
        check("rst sbr rdata", sbr_rdata, 32'h0);
        sbr_chk("rst STATUS", 1'b0, 3'd4, 32'h0, 4'h3, 1'b1, 32'h0, 1'b0);
        sbr_chk("rst PROGRESS", 1'b0, 3'd5, 32'h0, 4'h4, 1'b1, 32'h0, 1'b0);
        sbr_chk("rst LEN", 1'b0, 3'd3, 32'h0, 4'h5, 1'b1, 32'h0, 1'b0);
        tick(3);
        check("no traffic after rst", 32'(mgr_req), 32'h0);

        // two-word job
        mem[16'h100 >> 2] = 32'h0000_0003;
        mem[16'h104 >> 2] = 32'h8000_0000;
        cfg(3'd1, 32'h100); cfg(3'd2, 32'h200); cfg(3'd3, 32'd2); cfg(3'd0, 32'h1);
        wait_idle("job2");
        check("job2 out0", mem[16'h200 >> 2], 32'h0000_0002);
        // carry from word 0 is 1: 0x8000_0000 ^ 0xC000_0000
        check("job2 out1", mem[16'h204 >> 2], 32'h4000_0000);
        sbr_chk("job2 STATUS", 1'b0, 3'd4, 32'h0, 4'h6, 1'b1, 32'h2, 1'b0);
        sbr_chk("job2 PROGRESS", 1'b0, 3'd5, 32'h0, 4'h7, 1'b1, 32'd2, 1'b0);

        // zero-length start with interrupt enabled
        sbr_chk("w1c done", 1'b1, 3'd4, 32'h2, 4'h8, 1'b1, 32'h0, 1'b0);
        cfg(3'd3, 32'd0);
        cfg(3'd0, 32'h2);
        check("irq low before start", 32'(irq), 32'h0);
        q0 = req_cycles;
        cfg(3'd0, 32'h3);
        check("len0 irq", 32'(irq), 32'h1);
        sbr_chk("len0 STATUS", 1'b0, 3'd4, 32'h0, 4'h9, 1'b1, 32'h2, 1'b0);
        tick(5);
        check("len0 no mgr req", 32'(req_cycles - q0), 32'h0);
        sbr_chk("len0 w1c", 1'b1, 3'd4, 32'h2, 4'hA, 1'b1, 32'h0, 1'b0);
        check("irq cleared", 32'(irq), 32'h0);
        sbr_chk("len0 STATUS clr", 1'b0, 3'd4, 32'h0, 4'hB, 1'b1, 32'h0, 1'b0);

        // error on the second read of a four-word job
        mem[16'h500 >> 2] = 32'h1234_5679;
        mem[16'h504 >> 2] = 32'h0F0F_0F0F;
        cfg(3'd1, 32'h500); cfg(3'd2, 32'h600); cfg(3'd3, 32'd4);
        rd_count = 0; err_on_read = 2; t0 = txn_count;
        cfg(3'd0, 32'h1);
        wait_idle("errjob");
        err_on_read = 0;
        sbr_chk("err STATUS", 1'b0, 3'd4, 32'h0, 4'hC, 1'b1, 32'h6, 1'b0);
        sbr_chk("err PROGRESS", 1'b0, 3'd5, 32'h0, 4'hD, 1'b1, 32'd1, 1'b0);
        check("err txn count", 32'(txn_count - t0), 32'd3);
        check("err out0", mem[16'h600 >> 2], 32'h1B2E_7D45);
        check("err out1 untouched", mem[16'h604 >> 2], 32'hDEAD_BEEF);
        tick(10);
        check("err no further txn", 32'(txn_count - t0), 32'd3);

        // stalled sixteen-word job whose source wraps past 0xFFFC
        stall_max = 5; stab_err = 0;
        c = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] a;
            a = 16'hFFFC + 16'(4 * i);
            mem[a[15:2]] = $urandom;
            mem[(16'h400 >> 2) + i] = 32'h0;
            expd[i] = edge_op(mem[a[15:2]], c);
            c = mem[a[15:2]][0];
        end
        cfg(3'd1, 32'hFFFC); cfg(3'd2, 32'h400); cfg(3'd3, 32'd16); cfg(3'd0, 32'h1);
        sbr_chk("busy wr LEN", 1'b1, 3'd3, 32'd5, 4'h2, 1'b1, 32'h0, 1'b1);
        sbr_chk("busy wr SRC", 1'b1, 3'd1, 32'h40, 4'h3, 1'b1, 32'h0, 1'b1);
        sbr_chk("busy rd PROGRESS", 1'b0, 3'd5, 32'h0, 4'hE, 1'b0, 32'h0, 1'b0);
        sbr_chk("busy STATUS", 1'b0, 3'd4, 32'h0, 4'hF, 1'b1, 32'h1, 1'b0);
        wait_idle("job16");
        sbr_chk("job16 LEN kept", 1'b0, 3'd3, 32'h0, 4'h1, 1'b1, 32'd16, 1'b0);
        sbr_chk("job16 SRC kept", 1'b0, 3'd1, 32'h0, 4'h2, 1'b1, 32'hFFFC, 1'b0);
        sbr_chk("job16 STATUS", 1'b0, 3'd4, 32'h0, 4'h3, 1'b1, 32'h2, 1'b0);
        sbr_chk("job16 PROGRESS", 1'b0, 3'd5, 32'h0, 4'h4, 1'b1, 32'd16, 1'b0);
        for (int i = 0; i < 16; i++)
            check($sformatf("job16 out%0d", i), mem[(16'h400 >> 2) + i], expd[i]);
        check("stall stability", 32'(stab_err), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
